// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared state encoding and widths for the UART TX scheduler
package uart_tx_scheduler_pkg;
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      ISSUE      = 2'b01,
      WAIT_START = 2'b11,
      WAIT_DONE  = 2'b10
   } state_t;
   localparam int BYTE_W_DEF = 8;
   function automatic int msg_w(input int byte_w);
      return 2 * byte_w;
   endfunction
endpackage

// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter: one-hot round-robin pick from the pointer upward, pointer advanced past the finished grant
module uart_tx_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               adv,
   input  logic [PW-1:0]      last_idx,
   output logic [NUM_REQ-1:0] sel,
   output logic [PW-1:0]      sel_idx
);
   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;
   int            j;
   always_comb begin
      sel     = '0;
      sel_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr_q) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found   = 1'b1;
            sel[j]  = 1'b1;
            sel_idx = PW'(j);
         end
      end
      ptr_d = adv ? ((last_idx == PW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1) : ptr_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX between requesters posting 1- or 2-byte messages
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int BYTE_W        = BYTE_W_DEF,
   parameter int START_TIMEOUT = 7
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_REQ-1:0]          REQ_VALID,
   input  logic [NUM_REQ*2*BYTE_W-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]          REQ_TWO_BYTE,
   output logic [NUM_REQ-1:0]          REQ_DONE,
   output logic [NUM_REQ-1:0]          GNT,
   output logic [BYTE_W-1:0]           TX_P_DATA,
   output logic                        TX_DATA_VALID,
   input  logic                        TX_BUSY,
   output logic                        SCHED_BUSY,
   output logic [3:0]                  RETRY_CNT
);
   localparam int MW = msg_w(BYTE_W);
   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, sel;
   logic [PW-1:0]        gidx_q, gidx_d, sel_idx;
   logic [MW-1:0]        word_q, word_d;
   logic [BYTE_W-1:0]    pdata_q, pdata_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [3:0]           retry_q, retry_d;
   logic                 two_q, two_d, idx_q, idx_d, dv_q, dv_d, busy_q, busy_d, adv;
   uart_tx_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
      .clk(CLK), .rst(RST), .req(REQ_VALID), .adv(adv), .last_idx(gidx_q),
      .sel(sel), .sel_idx(sel_idx)
   );
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gidx_d  = gidx_q;
      word_d  = word_q;
      two_d   = two_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      done_d  = '0;
      adv     = 1'b0;
      // the strobe and its byte are registered out of ISSUE, so they appear while in WAIT_START
      dv_d    = state_q == ISSUE;
      pdata_d = (state_q == ISSUE) ? (idx_q ? word_q[MW-1:BYTE_W] : word_q[BYTE_W-1:0]) : pdata_q;
      case (state_q)
         IDLE:
            if (|REQ_VALID && !TX_BUSY) begin
               state_d = ISSUE;
               gnt_d   = sel;
               gidx_d  = sel_idx;
               word_d  = REQ_DATA[sel_idx*MW +: MW];
               two_d   = REQ_TWO_BYTE[sel_idx];
               idx_d   = 1'b0;
            end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT_START;
         end
         WAIT_START:
            if (TX_BUSY) state_d = WAIT_DONE;
            else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == TW'(START_TIMEOUT)) begin
                  state_d = ISSUE;
                  retry_d = (&retry_q) ? retry_q : retry_q + 1'b1;
               end
            end
         WAIT_DONE:
            if (!TX_BUSY) begin
               if (two_q && !idx_q) begin
                  idx_d   = 1'b1;
                  state_d = ISSUE;
               end else begin
                  done_d  = gnt_q;
                  adv     = 1'b1;
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         word_q  <= '0;
         two_q   <= 1'b0;
         idx_q   <= 1'b0;
         tmo_q   <= '0;
         retry_q <= '0;
         done_q  <= '0;
         dv_q    <= 1'b0;
         pdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gidx_q  <= gidx_d;
         word_q  <= word_d;
         two_q   <= two_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
         done_q  <= done_d;
         dv_q    <= dv_d;
         pdata_q <= pdata_d;
         busy_q  <= busy_d;
      end
   assign REQ_DONE      = done_q;
   assign GNT           = gnt_q;
   assign TX_P_DATA     = pdata_q;
   assign TX_DATA_VALID = dv_q;
   assign SCHED_BUSY    = busy_q;
   assign RETRY_CNT     = retry_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed vectors plus corner sequences against a behavioural UART TX
module tb_uart_tx_scheduler;
   localparam int START_TIMEOUT = 7;
   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  REQ_VALID, REQ_TWO_BYTE, REQ_DONE, GNT;
   logic [31:0] REQ_DATA;
   logic [7:0]  TX_P_DATA;
   logic        TX_DATA_VALID, TX_BUSY, SCHED_BUSY;
   logic [3:0]  RETRY_CNT;
   logic        glitch;
   int          bcnt = 0, nstrobe = 0, ign_at;
   int          total = 0, bad = 0;
   logic [1:0]  r_gnt, r_done;
   logic [7:0]  r_b [4];
   int          r_s_cyc [4];
   int          r_n, r_gnt_cyc, r_fall_first, r_fall_last, r_done_cyc;
   typedef struct {
      logic [1:0]  valid;
      logic [31:0] data;
      logic [1:0]  two;
      int          ign;
      logic [1:0]  e_gnt;
      int          e_n;
      logic [7:0]  e_b0, e_b1;
      logic [1:0]  e_done;
      logic [3:0]  e_retry;
   } vec_t;
   vec_t v [5];
   uart_tx_scheduler #(.NUM_REQ(2), .BYTE_W(8), .START_TIMEOUT(START_TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_TWO_BYTE(REQ_TWO_BYTE),
      .REQ_DONE(REQ_DONE), .GNT(GNT), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
      .TX_BUSY(TX_BUSY), .SCHED_BUSY(SCHED_BUSY), .RETRY_CNT(RETRY_CNT)
   );
   always #5 CLK = ~CLK;
   // UART TX model: busy for 11 cycles after a sampled strobe; strobe number ign_at is dropped
   always @(posedge CLK or posedge RST)
      if (RST) bcnt <= 0;
      else if (TX_DATA_VALID && bcnt == 0) begin
         nstrobe <= nstrobe + 1;
         if (nstrobe != ign_at) bcnt <= 11;
      end else if (bcnt > 0) bcnt <= bcnt - 1;
   assign TX_BUSY = (bcnt != 0) || glitch;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic run_msg(input logic [1:0] drop);
      logic pb;
      r_n = 0; r_gnt = '0; r_gnt_cyc = -1; r_fall_first = -1; r_fall_last = -1;
      r_done = '0; r_done_cyc = -1;
      pb = TX_BUSY;
      for (int c = 1; c <= 300; c++) begin
         @(negedge CLK);
         if (GNT != 0 && r_gnt_cyc < 0) begin r_gnt = GNT; r_gnt_cyc = c; end
         if (TX_DATA_VALID && r_n < 4) begin r_b[r_n] = TX_P_DATA; r_s_cyc[r_n] = c; r_n++; end
         if (pb && !TX_BUSY) begin
            if (r_fall_first < 0) r_fall_first = c;
            r_fall_last = c;
         end
         pb = TX_BUSY;
         if (REQ_DONE != 0) begin
            r_done = REQ_DONE; r_done_cyc = c;
            REQ_VALID = REQ_VALID & ~drop;
            break;
         end
      end
   endtask
   initial begin
      logic       seen;
      logic [7:0] sbyte;
      RST = 1'b1; REQ_VALID = '0; REQ_DATA = '0; REQ_TWO_BYTE = '0; glitch = 1'b0; ign_at = -1;
      v[0] = '{2'b01, 32'h0000_12A5, 2'b00, 0, 2'b01, 1, 8'hA5, 8'h00, 2'b01, 4'd0};
      v[1] = '{2'b10, 32'hBEEF_0000, 2'b10, 0, 2'b10, 2, 8'hEF, 8'hBE, 2'b10, 4'd0};
      v[2] = '{2'b01, 32'h0000_3C5A, 2'b00, 1, 2'b01, 2, 8'h5A, 8'h5A, 2'b01, 4'd1};
      v[3] = '{2'b10, 32'h7E81_0000, 2'b00, 0, 2'b10, 1, 8'h81, 8'h00, 2'b10, 4'd1};
      v[4] = '{2'b01, 32'h0000_C3D2, 2'b01, 0, 2'b01, 2, 8'hD2, 8'hC3, 2'b01, 4'd1};
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_gnt", GNT, 0);
      chk("rst_done", REQ_DONE, 0);
      chk("rst_dv", TX_DATA_VALID, 0);
      chk("rst_pdata", TX_P_DATA, 0);
      chk("rst_busy", SCHED_BUSY, 0);
      chk("rst_retry", RETRY_CNT, 0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ign_at = v[i].ign ? nstrobe : -1;
         REQ_DATA = v[i].data;
         REQ_TWO_BYTE = v[i].two;
         if (i == 0) begin
            glitch = 1'b1;
            REQ_VALID = v[i].valid;
            repeat (4) @(negedge CLK);
            chk("glitch_gnt", GNT, 0);
            glitch = 1'b0;
         end
         REQ_VALID = v[i].valid;
         run_msg(v[i].valid);
         chk($sformatf("v%0d_gnt", i), r_gnt, v[i].e_gnt);
         chk($sformatf("v%0d_gnt_lat", i), r_gnt_cyc, 1);
         chk($sformatf("v%0d_dv_lat", i), r_s_cyc[0], 2);
         chk($sformatf("v%0d_nstrobe", i), r_n, v[i].e_n);
         chk($sformatf("v%0d_b0", i), r_b[0], v[i].e_b0);
         if (v[i].e_n == 2) chk($sformatf("v%0d_b1", i), r_b[1], v[i].e_b1);
         chk($sformatf("v%0d_done", i), r_done, v[i].e_done);
         chk($sformatf("v%0d_done_lat", i), r_done_cyc - r_fall_last, 1);
         chk($sformatf("v%0d_retry", i), RETRY_CNT, v[i].e_retry);
         if (v[i].two != 0) chk($sformatf("v%0d_gap", i), r_s_cyc[1] - r_fall_first, 2);
         if (v[i].ign != 0) chk($sformatf("v%0d_reissue", i), r_s_cyc[1] - r_s_cyc[0], START_TIMEOUT + 1);
         @(negedge CLK);
         chk($sformatf("v%0d_idle", i), SCHED_BUSY, 0);
      end
      REQ_DATA = 32'h0000_4321; REQ_TWO_BYTE = 2'b01; REQ_VALID = 2'b01;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge CLK);
         seen = TX_BUSY && SCHED_BUSY;
      end
      chk("mid_reach_wait_done", seen, 1);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("mid_rst_gnt", GNT, 0);
      chk("mid_rst_pdata", TX_P_DATA, 0);
      chk("mid_rst_dv", TX_DATA_VALID, 0);
      chk("mid_rst_busy", SCHED_BUSY, 0);
      chk("mid_rst_retry", RETRY_CNT, 0);
      REQ_VALID = 2'b11; REQ_DATA = {16'h0022, 16'h0011}; REQ_TWO_BYTE = 2'b00;
      seen = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         seen = seen | (REQ_DONE != 0);
      end
      chk("mid_rst_no_done", seen, 0);
      RST = 1'b0;
      for (int m = 0; m < 4; m++) begin
         run_msg(m == 3 ? 2'b11 : 2'b00);
         chk($sformatf("rr%0d_gnt", m), r_gnt, (m % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("rr%0d_done", m), r_done, (m % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("rr%0d_byte", m), r_b[0], (m % 2 == 0) ? 8'h11 : 8'h22);
      end
      @(negedge CLK);
      REQ_DATA = 32'h0000_00AA; REQ_TWO_BYTE = 2'b00; REQ_VALID = 2'b01;
      seen = 1'b0; sbyte = '0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge CLK);
         if (TX_DATA_VALID) sbyte = TX_P_DATA;
         seen = TX_BUSY && (GNT != 0);
      end
      REQ_DATA = 32'h0000_0055; REQ_TWO_BYTE = 2'b01;
      run_msg(2'b01);
      chk("chg_byte", sbyte, 8'hAA);
      chk("chg_extra_strobes", r_n, 0);
      chk("chg_done", r_done, 2'b01);
      chk("chg_pdata_hold", TX_P_DATA, 8'hAA);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
